// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch resolve controller: operand width,
// branch condition encodings and controller state encoding.
package branch_resolve_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

endpackage

// File: rtl/branch_resolve_ctrl_cmp.sv
// Purely combinational branch condition evaluator; reserved encodings
// (010/011) resolve as not taken.
module branch_cmp
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      funct3,
  output logic            taken
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   eq;
  logic                   lt_s;
  logic                   lt_u;

  assign rs1_s = rs1;
  assign rs2_s = rs2;
  assign eq    = (rs1 == rs2);
  assign lt_s  = (rs1_s < rs2_s);
  assign lt_u  = (rs1 < rs2);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = ~eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = ~lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = ~lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: captures one branch op, resolves it in a single
// EVAL cycle, and holds a redirect to fetch until accepted or aborted.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_funct3,
  input  logic            in_pred_taken,
  input  logic            abort,
  output logic            res_valid,
  output logic            res_taken,
  output logic            res_mispredict,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  input  logic            redir_ready,
  output logic            flush,
  output logic [XLEN-1:0] cnt_branch,
  output logic [XLEN-1:0] cnt_taken,
  output logic [XLEN-1:0] cnt_mispred
);

  state_t          state;
  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] rs1_p0;
  logic [XLEN-1:0] rs2_p0;
  logic [XLEN-1:0] imm_p0;
  logic [2:0]      funct3_p0;
  logic            pred_p0;

  logic            taken_w;
  logic            mispred_w;
  logic [XLEN-1:0] target_w;

  function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v,
                                              input logic            en);
    if (en && (v != '1))
      return v + XLEN'(1);
    return v;
  endfunction

  branch_cmp u_cmp (
    .rs1    (rs1_p0),
    .rs2    (rs2_p0),
    .funct3 (funct3_p0),
    .taken  (taken_w)
  );

  assign mispred_w = taken_w ^ pred_p0;
  assign target_w  = pc_p0 + (taken_w ? imm_p0 : XLEN'(4));

  // Abort in the same cycle must be able to cancel the resolve strobe and flush.
  assign in_ready       = (state == ST_IDLE);
  assign res_valid      = (state == ST_EVAL) & ~abort;
  assign res_taken      = res_valid & taken_w;
  assign res_mispredict = res_valid & mispred_w;
  assign flush          = redir_valid & redir_ready & ~abort;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pc_p0       <= '0;
      rs1_p0      <= '0;
      rs2_p0      <= '0;
      imm_p0      <= '0;
      funct3_p0   <= '0;
      pred_p0     <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      cnt_branch  <= '0;
      cnt_taken   <= '0;
      cnt_mispred <= '0;
    end else begin
      case (state)
        // Capture stage boundary
        ST_IDLE: begin
          if (in_valid && !abort) begin
            pc_p0     <= in_pc;
            rs1_p0    <= in_rs1;
            rs2_p0    <= in_rs2;
            imm_p0    <= in_imm;
            funct3_p0 <= in_funct3;
            pred_p0   <= in_pred_taken;
            state     <= ST_EVAL;
          end
        end
        // Resolve stage boundary
        ST_EVAL: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            cnt_branch  <= sat_inc(cnt_branch, 1'b1);
            cnt_taken   <= sat_inc(cnt_taken, taken_w);
            cnt_mispred <= sat_inc(cnt_mispred, mispred_w);
            if (mispred_w) begin
              redir_valid <= 1'b1;
              redir_pc    <= target_w;
              state       <= ST_REDIRECT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        // Redirect handshake boundary
        ST_REDIRECT: begin
          if (abort || redir_ready) begin
            redir_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          redir_valid <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed and randomized checks of branch_resolve_ctrl against a behavioural
// model of branch resolution, redirect handshake and saturating counters.
module tb_branch_resolve_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_pred_taken = 1'b0;
  logic        abort = 1'b0;
  logic        res_valid, res_taken, res_mispredict;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready = 1'b0;
  logic        flush;
  logic [31:0] cnt_branch, cnt_taken, cnt_mispred;

  int     total = 0;
  int     passed = 0;
  longint m_branch = 0, m_taken = 0, m_mis = 0;

  branch_resolve_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_imm         (in_imm),
    .in_funct3      (in_funct3),
    .in_pred_taken  (in_pred_taken),
    .abort          (abort),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .res_mispredict (res_mispredict),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .redir_ready    (redir_ready),
    .flush          (flush),
    .cnt_branch     (cnt_branch),
    .cnt_taken      (cnt_taken),
    .cnt_mispred    (cnt_mispred)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Branch rules from the ISA: signed compare via sign-bit bias onto unsigned order.
  function automatic bit model_taken(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] b);
    bit [31:0] ab, bb;
    ab = a ^ 32'h8000_0000;
    bb = b ^ 32'h8000_0000;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return ab < bb;
      3'd5:    return ab >= bb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic longint sat1(input longint v, input bit en);
    return (en && v < 64'hFFFF_FFFF) ? v + 1 : v;
  endfunction

  task automatic model_count(input bit t, input bit m);
    m_branch = sat1(m_branch, 1'b1);
    m_taken  = sat1(m_taken, t);
    m_mis    = sat1(m_mis, m);
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".cnt_branch"}, cnt_branch, m_branch[31:0]);
    check({tag, ".cnt_taken"}, cnt_taken, m_taken[31:0]);
    check({tag, ".cnt_mispred"}, cnt_mispred, m_mis[31:0]);
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [2:0] f3, input logic pred);
    in_valid = 1'b1;
    in_pc = pc; in_rs1 = a; in_rs2 = b; in_imm = imm;
    in_funct3 = f3; in_pred_taken = pred;
  endtask

  task automatic scramble();
    in_pc = $urandom; in_rs1 = $urandom; in_rs2 = $urandom; in_imm = $urandom;
    in_funct3 = 3'($urandom); in_pred_taken = 1'($urandom);
  endtask

  // Entered at a falling edge with the controller idle; leaves it idle at a falling edge.
  task automatic do_op(input string tag, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [2:0] f3,
                       input logic pred, input int stall);
    bit          t, m;
    logic [31:0] tgt;
    t   = model_taken(f3, a, b);
    m   = t ^ pred;
    tgt = t ? pc + imm : pc + 32'd4;
    check1({tag, ".in_ready_idle"}, in_ready, 1'b1);
    present(pc, a, b, imm, f3, pred);
    @(negedge clock);
    in_valid = 1'($urandom);
    scramble();
    #1;
    check1({tag, ".res_valid"}, res_valid, 1'b1);
    check1({tag, ".res_taken"}, res_taken, t);
    check1({tag, ".res_mispredict"}, res_mispredict, m);
    check1({tag, ".in_ready_eval"}, in_ready, 1'b0);
    check1({tag, ".redir_valid_eval"}, redir_valid, 1'b0);
    model_count(t, m);
    @(negedge clock);
    check1({tag, ".res_valid_after"}, res_valid, 1'b0);
    check_counters(tag);
    if (m) begin
      check1({tag, ".redir_valid"}, redir_valid, 1'b1);
      check({tag, ".redir_pc"}, redir_pc, tgt);
      check1({tag, ".flush_wait"}, flush, 1'b0);
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'($urandom);
        scramble();
        @(negedge clock);
        check1({tag, ".redir_hold"}, redir_valid, 1'b1);
        check({tag, ".redir_pc_stable"}, redir_pc, tgt);
      end
      redir_ready = 1'b1;
      #1;
      check1({tag, ".flush"}, flush, 1'b1);
      @(negedge clock);
      redir_ready = 1'b0;
      check1({tag, ".redir_done"}, redir_valid, 1'b0);
      check1({tag, ".flush_done"}, flush, 1'b0);
    end else begin
      check1({tag, ".no_redir"}, redir_valid, 1'b0);
    end
    in_valid = 1'b0;
    check1({tag, ".in_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    // Reset state
    #2;
    check1("rst.in_ready", in_ready, 1'b1);
    check1("rst.res_valid", res_valid, 1'b0);
    check1("rst.res_taken", res_taken, 1'b0);
    check1("rst.res_mispredict", res_mispredict, 1'b0);
    check1("rst.redir_valid", redir_valid, 1'b0);
    check("rst.redir_pc", redir_pc, 32'h0);
    check1("rst.flush", flush, 1'b0);
    check_counters("rst");
    @(negedge clock);
    reset_n = 1'b1;

    // Directed cases, back-to-back where no redirect is needed
    do_op("beq_hit", 32'h200, 32'd5, 32'd5, 32'h10, 3'b000, 1'b1, 0);
    do_op("blt_neg", 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'b100, 1'b0, 0);
    do_op("bltu_big", 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'b110, 1'b1, 3);
    do_op("bne_wrap", 32'hFFFF_FFF0, 32'd1, 32'd2, 32'h20, 3'b001, 1'b0, 0);
    do_op("bge_eq", 32'h300, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF8, 3'b101, 1'b0, 1);
    do_op("bgeu_lo", 32'h400, 32'd0, 32'd1, 32'h8, 3'b111, 1'b0, 0);
    do_op("f3_010", 32'h500, 32'd7, 32'd7, 32'h8, 3'b010, 1'b0, 0);
    do_op("f3_011", 32'h500, 32'd7, 32'd9, 32'h8, 3'b011, 1'b1, 2);

    // Abort in idle blocks capture
    present(32'h600, 32'd1, 32'd1, 32'h10, 3'b000, 1'b0);
    abort = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    abort = 1'b0;
    #1;
    check1("abort_idle.res_valid", res_valid, 1'b0);
    check1("abort_idle.in_ready", in_ready, 1'b1);
    @(negedge clock);
    check1("abort_idle.res_valid2", res_valid, 1'b0);
    check_counters("abort_idle");

    // Abort in eval kills strobe, counters and redirect
    present(32'h700, 32'd1, 32'd1, 32'h10, 3'b000, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    abort = 1'b1;
    #1;
    check1("abort_eval.res_valid", res_valid, 1'b0);
    check1("abort_eval.res_taken", res_taken, 1'b0);
    check1("abort_eval.res_mispredict", res_mispredict, 1'b0);
    @(negedge clock);
    abort = 1'b0;
    check1("abort_eval.in_ready", in_ready, 1'b1);
    check1("abort_eval.redir_valid", redir_valid, 1'b0);
    check_counters("abort_eval");

    // Abort beats redir_ready in redirect
    present(32'h800, 32'd3, 32'd4, 32'h24, 3'b001, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    model_count(1'b1, 1'b1);
    @(negedge clock);
    check1("abort_redir.redir_valid", redir_valid, 1'b1);
    check("abort_redir.redir_pc", redir_pc, 32'h824);
    redir_ready = 1'b1;
    abort = 1'b1;
    #1;
    check1("abort_redir.flush", flush, 1'b0);
    @(negedge clock);
    abort = 1'b0;
    redir_ready = 1'b0;
    check1("abort_redir.dropped", redir_valid, 1'b0);
    check1("abort_redir.in_ready", in_ready, 1'b1);
    check_counters("abort_redir");

    // Reset in redirect drops it without flush
    present(32'h900, 32'd3, 32'd3, 32'h10, 3'b000, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    check1("rst_redir.redir_valid", redir_valid, 1'b1);
    redir_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check1("rst_redir.flush", flush, 1'b0);
    check1("rst_redir.redir_valid0", redir_valid, 1'b0);
    check("rst_redir.redir_pc", redir_pc, 32'h0);
    check1("rst_redir.in_ready", in_ready, 1'b1);
    m_branch = 0; m_taken = 0; m_mis = 0;
    check_counters("rst_redir");
    @(negedge clock);
    redir_ready = 1'b0;
    reset_n = 1'b1;
    check1("rst_redir.in_ready_out", in_ready, 1'b1);

    // Counter saturation from a preset near the top
    force dut.cnt_branch = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_branch;
    m_branch = 64'hFFFF_FFFE;
    do_op("sat1", 32'hA00, 32'd1, 32'd2, 32'h8, 3'b010, 1'b0, 0);
    do_op("sat2", 32'hA00, 32'd1, 32'd2, 32'h8, 3'b010, 1'b0, 0);
    do_op("sat3", 32'hA00, 32'd1, 32'd1, 32'h8, 3'b000, 1'b1, 0);
    check("sat.cnt_branch_max", cnt_branch, 32'hFFFF_FFFF);

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        default: b = $urandom;
      endcase
      do_op($sformatf("rnd%0d", n), $urandom, a, b, $urandom, 3'($urandom), 1'($urandom),
            $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 Port list SHALL be as follows; one clock domain; reset asynchronous, active-low.
REQ-002 clock  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  branch op offered.
REQ-005 in_ready  out  1  controller accepts op; equals 1 only in IDLE.
REQ-006 in_pc, in_rs1, in_rs2, in_imm  in  32 each  branch PC, operands, sign-extended B-immediate.
REQ-007 in_funct3  in  3  branch condition; in_pred_taken  in  1  fetch prediction.
REQ-008 abort  in  1  kill from an older instruction.
REQ-009 res_valid  out  1  one-cycle resolve strobe; res_taken, res_mispredict  out  1 each.
REQ-010 redir_valid  out  1  redirect request; redir_pc  out  32  redirect target; redir_ready  in  1  fetch acceptance.
REQ-011 flush  out  1  one-cycle kill of younger ops.
REQ-012 cnt_branch, cnt_taken, cnt_mispred  out  32 each  performance counters.

Function
REQ-013 FSM states SHALL be IDLE, EVAL and REDIRECT.
REQ-014 IDLE: in_valid & in_ready SHALL capture all in_* fields into registers; next state EVAL.
REQ-015 EVAL SHALL last exactly one cycle, with res_valid=1 and res_taken/res_mispredict driven from captured fields.
REQ-016 Conditions SHALL be: funct3 000 BEQ (eq), 001 BNE (ne), 100 BLT (signed lt), 101 BGE (signed ge), 110 BLTU (unsigned lt), 111 BGEU (unsigned ge); 010/011 not taken.
REQ-017 Mispredict SHALL be taken XOR pred_taken.
REQ-018 Target SHALL be pc+imm when taken, else pc+4; both mod 2^32, wrap silently.
REQ-019 EVAL exit: mispredict -> REDIRECT with redir_pc registered; otherwise -> IDLE.
REQ-020 REDIRECT: redir_valid=1; redir_pc SHALL stay stable until redir_valid & redir_ready.
REQ-021 flush SHALL equal redir_valid & redir_ready; that cycle returns the FSM to IDLE.
REQ-022 Latency: accept at cycle N -> res_valid at N+1 -> redir_valid at N+2 earliest; back-to-back correct-predict ops SHALL accept every 2 cycles.
REQ-023 abort SHALL force IDLE next cycle from any state, dropping the pending redirect.
REQ-024 In IDLE, abort SHALL block capture.
REQ-025 In EVAL, abort SHALL force res_valid=0 and suppress counter updates.
REQ-026 In REDIRECT, abort SHALL win over redir_ready: flush=0.
REQ-027 In EVAL, cnt_branch SHALL increment by 1.
REQ-028 In EVAL, cnt_taken SHALL increment by 1 if taken.
REQ-029 In EVAL, cnt_mispred SHALL increment by 1 if mispredict.
REQ-030 Each counter SHALL saturate at 0xFFFFFFFF.
REQ-031 in_* fields SHALL be ignored when in_ready=0.

Reset
REQ-032 reset_n low SHALL asynchronously force state IDLE and set to 0: res_valid, res_taken, res_mispredict, redir_valid, redir_pc, flush, all counters, captured fields.
REQ-033 Reset deassertion SHALL take effect on the next rising clock edge; in_ready=1 the first cycle out of reset.
REQ-034 Reset mid-REDIRECT SHALL drop the redirect without flush.

Structure
REQ-035 Shared package SHALL hold the funct3 encodings, the FSM state enum (2 bits) and the width constant XLEN=32.
REQ-036 Condition evaluation SHALL be one sub-module, branch_cmp (rs1, rs2, funct3 -> taken), purely combinational.
REQ-037 All other logic, including FSM, counters and target adder, SHALL reside in branch_resolve_ctrl.

Verification
REQ-038 BEQ, rs1=rs2=5, pred_taken=1 -> res_valid at N+1, taken=1, mispredict=0, no redir; cnt_branch=1, cnt_taken=1.
REQ-039 BLT, rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x40, pred=0 -> taken, redir_pc=0x140 at N+2; flush on handshake.
REQ-040 BLTU with the same operands, pred=1 -> not taken, redir_pc=0x104; redir_ready low 3 cycles keeps redir_pc stable.
REQ-041 pc=0xFFFFFFF0, imm=0x20, BNE taken, pred=0 -> redir_pc=0x00000010 (wrap).
REQ-042 abort in REDIRECT together with redir_ready=1 -> flush=0, IDLE next cycle, in_ready=1.
REQ-043 funct3=010 -> not taken; cnt_branch preset near max -> counter holds 0xFFFFFFFF after saturation.
